// File: rtl/bin2bcd_fmt.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with Seg_Display formatting.
// Optional leading-zero blanking of dsp_data is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_fmt #(
    parameter int         BIN_W       = 8,
    parameter int         DIGITS      = 3,
    parameter int         SLOTS       = 8,
    parameter logic [3:0] BLANK_CODE  = 4'd10,
    parameter logic [3:0] PREFIX_CODE = 4'd15
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_vld,
    output logic                  bin_rdy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [4*SLOTS-1:0]    dsp_data,
    output logic                  out_vld,
    output logic                  ovf,
    output logic                  busy
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int DSP_W = 4 * SLOTS;
    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam int CMP_W = (BIN_W > 40) ? BIN_W : 40;

    function automatic logic [CMP_W-1:0] pow10_m1(input int n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < n; i++) p = p * CMP_W'(10);
        return p - CMP_W'(1);
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = pow10_m1(DIGITS);
    localparam logic [DSP_W-1:0] DSP_RST = {PREFIX_CODE, {(SLOTS-1){BLANK_CODE}}};

    // Handshake: a transfer happens on a rising edge where bin_vld and bin_rdy are both high.
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FMT} state_t;

    state_t           state, state_nxt;
    logic [BIN_W-1:0] sr;
    logic [ACC_W-1:0] acc, acc_adj, bcd_fmt, disp_dig;
    logic [DSP_W-1:0] dsp_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ovf_flag;
    logic             accept;

    assign bin_rdy = (state == ST_IDLE);
    assign busy    = ~bin_rdy;
    assign accept  = bin_vld & bin_rdy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bin_vld) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(BIN_W - 1)) state_nxt = ST_FMT;
            ST_FMT:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    // Carry out of the top digit is dropped; the overflow flag already covers it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else if (accept) begin
            sr       <= bin_in;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= (CMP_W'(bin_in) > MAX_VAL);
        end else if (state == ST_SHIFT) begin
            acc <= ACC_W'({acc_adj, sr[BIN_W-1]});
            sr  <= {sr[BIN_W-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bcd_fmt  = ovf_flag ? {DIGITS{4'h9}} : acc;
        disp_dig = bcd_fmt;
`ifdef BIN2BCD_BLANK_EN
        begin : blank_scan
            logic lead;
            lead = 1'b1;
            if (!ovf_flag) begin
                for (int d = DIGITS - 1; d >= 1; d--) begin
                    if (lead && bcd_fmt[4*d +: 4] == 4'd0) disp_dig[4*d +: 4] = BLANK_CODE;
                    else lead = 1'b0;
                end
            end
        end
`endif
        dsp_nxt = {SLOTS{BLANK_CODE}};
        for (int s = 0; s < DIGITS; s++) dsp_nxt[4*s +: 4] = disp_dig[4*s +: 4];
        dsp_nxt[DSP_W-1 -: 4] = PREFIX_CODE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bcd_out  <= '0;
            dsp_data <= DSP_RST;
            ovf      <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            out_vld <= (state == ST_FMT);
            if (state == ST_FMT) begin
                bcd_out  <= bcd_fmt;
                dsp_data <= dsp_nxt;
                ovf      <= ovf_flag;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_fmt.sv
// Bench for bin2bcd_fmt: default instance plus a DIGITS=2 instance for overflow saturation.
// Expectations follow BIN2BCD_BLANK_EN the same way the design does.
module tb_bin2bcd_fmt;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [7:0]  bin_in1, bin_in2;
    logic        bin_vld1, bin_vld2, bin_rdy1, bin_rdy2;
    logic [11:0] bcd_out1;
    logic [7:0]  bcd_out2;
    logic [31:0] dsp1, dsp2;
    logic        out_vld1, out_vld2, ovf1, ovf2, busy1, busy2;

    bin2bcd_fmt dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bin_in(bin_in1), .bin_vld(bin_vld1),
        .bin_rdy(bin_rdy1), .bcd_out(bcd_out1), .dsp_data(dsp1), .out_vld(out_vld1),
        .ovf(ovf1), .busy(busy1)
    );

    bin2bcd_fmt #(.DIGITS(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bin_in(bin_in2), .bin_vld(bin_vld2),
        .bin_rdy(bin_rdy2), .bcd_out(bcd_out2), .dsp_data(dsp2), .out_vld(out_vld2),
        .ovf(ovf2), .busy(busy2)
    );

    int errors = 0, checks = 0, cyc = 0;
    int vld_cnt1 = 0, vld_cnt2 = 0, last_vld1 = -1;
    bit free_run = 1'b0;
    logic [44:0] exp_q1[$];
    logic [40:0] exp_q2[$];
    int lat_q1[$], lat_q2[$];
    logic [44:0] e1;
    logic [40:0] e2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference by division, independent of the shift-and-add-3 datapath.
    function automatic logic [44:0] ref1(input int v);
        logic [11:0] b;
        logic [31:0] d;
        b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        d = {4'hF, 16'hAAAA, b};
        if (BLANK && (v / 100) == 0) begin
            d[11:8] = 4'hA;
            if (((v / 10) % 10) == 0) d[7:4] = 4'hA;
        end
        return {1'b0, b, d};
    endfunction

    // Accept watcher: timestamps every handshake; in free-run mode also issues the expectation.
    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst_n && bin_vld1 && bin_rdy1) begin
            lat_q1.push_back(cyc);
            if (free_run) exp_q1.push_back(ref1(int'(bin_in1)));
        end
        if (sys_rst_n && bin_vld2 && bin_rdy2) lat_q2.push_back(cyc);
    end

    always @(negedge sys_clk) begin
        if (out_vld1) begin
            vld_cnt1++;
            if (exp_q1.size() == 0 || lat_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_vld: out_vld=1 required 0");
            end else begin
                e1 = exp_q1.pop_front();
                chk("dut1_ovf", 64'(ovf1), 64'(e1[44]));
                chk("dut1_bcd", 64'(bcd_out1), 64'(e1[43:32]));
                chk("dut1_dsp", 64'(dsp1), 64'(e1[31:0]));
                chk("dut1_latency", 64'(cyc - lat_q1.pop_front()), 64'd9);
                chk("dut1_rdy_at_vld", 64'(bin_rdy1), 64'd1);
                chk("dut1_busy_at_vld", 64'(busy1), 64'd0);
            end
            if (free_run && last_vld1 >= 0) chk("dut1_period", 64'(cyc - last_vld1), 64'd10);
            last_vld1 = cyc;
        end
    end

    always @(negedge sys_clk) begin
        if (out_vld2) begin
            vld_cnt2++;
            if (exp_q2.size() == 0 || lat_q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2_unexpected_vld: out_vld=1 required 0");
            end else begin
                e2 = exp_q2.pop_front();
                chk("dut2_ovf", 64'(ovf2), 64'(e2[40]));
                chk("dut2_bcd", 64'(bcd_out2), 64'(e2[39:32]));
                chk("dut2_dsp", 64'(dsp2), 64'(e2[31:0]));
                chk("dut2_latency", 64'(cyc - lat_q2.pop_front()), 64'd9);
            end
        end
    end

    task automatic send1(input logic [7:0] v, input logic [44:0] e);
        int n = 0;
        while (!bin_rdy1 && n < 100) begin @(posedge sys_clk); #1; n++; end
        if (!bin_rdy1) begin
            checks++; errors++;
            $display("FAIL dut1_rdy_timeout: bin_rdy=0 required 1");
        end else begin
            exp_q1.push_back(e);
            bin_in1 = v; bin_vld1 = 1'b1;
            @(posedge sys_clk); #1;
            bin_vld1 = 1'b0;
            bin_in1 = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send2(input logic [7:0] v, input logic [40:0] e);
        int n = 0;
        while (!bin_rdy2 && n < 100) begin @(posedge sys_clk); #1; n++; end
        if (!bin_rdy2) begin
            checks++; errors++;
            $display("FAIL dut2_rdy_timeout: bin_rdy=0 required 1");
        end else begin
            exp_q2.push_back(e);
            bin_in2 = v; bin_vld2 = 1'b1;
            @(posedge sys_clk); #1;
            bin_vld2 = 1'b0;
            bin_in2 = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 200) begin
            @(posedge sys_clk); #1; n++;
        end
        chk("drain_q1", 64'(exp_q1.size()), 64'd0);
        chk("drain_q2", 64'(exp_q2.size()), 64'd0);
    endtask

    task automatic chk_reset();
        chk("rst_bcd1", 64'(bcd_out1), 64'd0);
        chk("rst_dsp1", 64'(dsp1), 64'hFAAAAAAA);
        chk("rst_vld1", 64'(out_vld1), 64'd0);
        chk("rst_ovf1", 64'(ovf1), 64'd0);
        chk("rst_rdy1", 64'(bin_rdy1), 64'd1);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_bcd2", 64'(bcd_out2), 64'd0);
        chk("rst_dsp2", 64'(dsp2), 64'hFAAAAAAA);
    endtask

    initial begin
        int c0;
        bin_in1 = '0; bin_vld1 = 1'b0; bin_in2 = '0; bin_vld2 = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // Directed, back-to-back at full throughput.
        send1(8'd42,  {1'b0, 12'h042, BLANK ? 32'hFAAAAA42 : 32'hFAAAA042});
        send1(8'd0,   {1'b0, 12'h000, BLANK ? 32'hFAAAAAA0 : 32'hFAAAA000});
        send1(8'd7,   {1'b0, 12'h007, BLANK ? 32'hFAAAAAA7 : 32'hFAAAA007});
        send1(8'd255, {1'b0, 12'h255, 32'hFAAAA255});
        send1(8'd100, {1'b0, 12'h100, 32'hFAAAA100});
        send1(8'd10,  {1'b0, 12'h010, BLANK ? 32'hFAAAAA10 : 32'hFAAAA010});
        drain();

        send2(8'd150, {1'b1, 8'h99, 32'hFAAAAA99});
        send2(8'd5,   {1'b0, 8'h05, BLANK ? 32'hFAAAAAA5 : 32'hFAAAAA05});
        send2(8'd99,  {1'b0, 8'h99, 32'hFAAAAA99});
        send2(8'd100, {1'b1, 8'h99, 32'hFAAAAA99});
        send2(8'd0,   {1'b0, 8'h00, BLANK ? 32'hFAAAAAA0 : 32'hFAAAAA00});
        drain();

        for (int v = 0; v < 256; v++) send1(8'(v), ref1(v));
        drain();

        // bin_vld held high, bin_in scrambled every cycle.
        last_vld1 = -1;
        c0 = vld_cnt1;
        free_run = 1'b1;
        bin_vld1 = 1'b1;
        bin_in1 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk); #1;
            bin_in1 = 8'($urandom_range(0, 255));
        end
        bin_vld1 = 1'b0;
        @(negedge sys_clk); #1;
        free_run = 1'b0;
        chk("free_run_count", 64'(vld_cnt1 - c0), 64'd10);
        drain();

        // Reset in the middle of a conversion.
        c0 = vld_cnt1;
        send1(8'd200, {1'b0, 12'h200, 32'hFAAAA200});
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        exp_q1.delete();
        lat_q1.delete();
        @(negedge sys_clk);
        chk_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (12) @(posedge sys_clk);
        #1;
        chk("no_vld_after_reset", 64'(vld_cnt1 - c0), 64'd0);
        chk("rdy_after_reset", 64'(bin_rdy1), 64'd1);
        send1(8'd9, {1'b0, 12'h009, BLANK ? 32'hFAAAAAA9 : 32'hFAAAA009});
        drain();
        chk("vld_after_recover", 64'(vld_cnt1 - c0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
